// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the conv2d window generator.
// The window is a row-major 3x3 array, and row 0 holds the oldest image line.
package conv2d_pkg;

  localparam int KERNEL_DIM = 3;
  localparam int WIN_ELEMS  = KERNEL_DIM * KERNEL_DIM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } win_state_e;

  // Flat index of window element (r,c).
  function automatic int win_idx(input int r, input int c);
    return KERNEL_DIM * r + c;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// One image line of storage: a RAM with a registered 1-clock read.
// A read and a write to the same address in one cycle return the old word.
module conv2d_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv2d_window_gen.sv
// Turns a raster pixel stream into 3x3 windows. Each window appears one clock after the pixel that completes it.
// Input is stalled only while the single output register holds an unconsumed window.
module conv2d_window_gen
  import conv2d_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DIM_WIDTH-1:0]            cfg_width,
  input  logic [DIM_WIDTH-1:0]            cfg_height,
  input  logic [DATA_WIDTH-1:0]           s_pix_data,
  input  logic                            s_pix_valid,
  output logic                            s_pix_ready,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0] m_win_data,
  output logic [DIM_WIDTH-1:0]            m_win_row,
  output logic [DIM_WIDTH-1:0]            m_win_col,
  output logic                            m_win_valid,
  input  logic                            m_win_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_WIDTH:0]   MAX_W_EXT = (DIM_WIDTH+1)'(MAX_WIDTH);
  localparam logic [DIM_WIDTH-1:0] K_DIM     = DIM_WIDTH'(KERNEL_DIM);
  localparam logic [DIM_WIDTH-1:0] EDGE      = DIM_WIDTH'(KERNEL_DIM - 1);
  localparam logic [DIM_WIDTH-1:0] ONE       = DIM_WIDTH'(1);

  typedef logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_t;

  win_state_e           state_q, state_d;
  logic [DIM_WIDTH-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0] x_q, x_d, y_q, y_d;
  win_t                 win_q, win_d;
  win_t                 out_q, out_d;
  logic [DIM_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic                 vld_q, vld_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                  pix_rdy;
  logic                  pix_acc;
  logic                  cfg_ok;
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  assign pix_rdy = (state_q == ST_RUN) && (!vld_q || m_win_ready);
  assign pix_acc = s_pix_valid && pix_rdy;
  assign cfg_ok  = (cfg_width >= K_DIM) && ({1'b0, cfg_width} <= MAX_W_EXT) &&
                   (cfg_height >= K_DIM);

  // Read address tracks the next x so the old words are ready when that pixel arrives.
  conv2d_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_lb0 (
    .clk    (clk),
    .we_i   (pix_acc),
    .waddr_i(x_q[AW-1:0]),
    .wdata_i(s_pix_data),
    .raddr_i(x_d[AW-1:0]),
    .rdata_o(lb0_rd)
  );

  conv2d_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_lb1 (
    .clk    (clk),
    .we_i   (pix_acc),
    .waddr_i(x_q[AW-1:0]),
    .wdata_i(lb0_rd),
    .raddr_i(x_d[AW-1:0]),
    .rdata_o(lb1_rd)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    out_d   = out_q;
    row_d   = row_q;
    col_d   = col_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (vld_q && m_win_ready) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = ST_RUN;
            w_d     = cfg_width;
            h_d     = cfg_height;
            x_d     = '0;
            y_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (pix_acc) begin
          for (int c = 0; c < KERNEL_DIM - 1; c++) begin
            for (int r = 0; r < KERNEL_DIM; r++) begin
              win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
            end
          end
          win_d[win_idx(0, KERNEL_DIM - 1)] = lb1_rd;
          win_d[win_idx(1, KERNEL_DIM - 1)] = lb0_rd;
          win_d[win_idx(2, KERNEL_DIM - 1)] = s_pix_data;

          if ((x_q >= EDGE) && (y_q >= EDGE)) begin
            out_d = win_d;
            vld_d = 1'b1;
            row_d = y_q - EDGE;
            col_d = x_q - EDGE;
          end

          if (x_q == w_q - ONE) begin
            x_d = '0;
            if (y_q == h_q - ONE) begin
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + ONE;
            end
          end else begin
            x_d = x_q + ONE;
          end
        end
      end

      ST_DRAIN: begin
        if (vld_q && m_win_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      out_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      out_q   <= out_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_pix_ready = pix_rdy;
  assign m_win_data  = out_q;
  assign m_win_row   = row_q;
  assign m_win_col   = col_q;
  assign m_win_valid = vld_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_conv2d_window_gen.sv
// Scoreboard bench for conv2d_window_gen: the driver queues expected windows, and the monitor pops and compares them on each handshake.
module tb_conv2d_window_gen;

  localparam int DW   = 8;
  localparam int MAXW = 1024;
  localparam int DIMW = 16;

  typedef struct packed {
    logic [9*DW-1:0] dat;
    logic [DIMW-1:0] row;
    logic [DIMW-1:0] col;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [DIMW-1:0] cfg_width = '0;
  logic [DIMW-1:0] cfg_height = '0;
  logic [DW-1:0]   s_pix_data = '0;
  logic            s_pix_valid = 1'b0;
  logic            s_pix_ready;
  logic [9*DW-1:0] m_win_data;
  logic [DIMW-1:0] m_win_row, m_win_col;
  logic            m_win_valid;
  logic            m_win_ready = 1'b1;
  logic            busy, done, cfg_err;

  conv2d_window_gen #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW), .DIM_WIDTH(DIMW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .s_pix_data (s_pix_data),
    .s_pix_valid(s_pix_valid),
    .s_pix_ready(s_pix_ready),
    .m_win_data (m_win_data),
    .m_win_row  (m_win_row),
    .m_win_col  (m_win_col),
    .m_win_valid(m_win_valid),
    .m_win_ready(m_win_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  int cyc = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  bit first_seen = 0;
  logic [9*DW-1:0] first_dat = '0;
  int rdy_mode = 0;
  bit hold_vld = 0;
  exp_t hold_dat;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always high, or a 1-0-0-1 rhythm with occasional random flips.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_win_ready = 1'b1;
    else if ($urandom_range(0, 7) == 0) m_win_ready = ~m_win_ready;
    else m_win_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  end

  // Monitor: compares each handshake and checks that a stalled window is held unchanged.
  always @(negedge clk) begin
    exp_t cur, e;
    cur = '{dat: m_win_data, row: m_win_row, col: m_win_col};
    if (hold_vld) begin
      check("stall_valid_held", {127'b0, m_win_valid}, 128'd1);
      check("stall_data_stable", {24'b0, cur}, {24'b0, hold_dat});
    end
    hold_vld = m_win_valid && !m_win_ready && !reset;
    hold_dat = cur;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_win_valid && m_win_ready && !reset) begin
      if (win_cnt > 0 && cyc != last_hs_cyc + 1) gap_cnt++;
      last_hs_cyc = cyc;
      win_cnt++;
      if (!first_seen) begin
        first_seen = 1;
        first_dat  = m_win_data;
      end
      if (sb.size() == 0) begin
        check("unexpected_window", {24'b0, cur}, 128'd0);
      end else begin
        e = sb.pop_front();
        check("win_data", {56'b0, cur.dat}, {56'b0, e.dat});
        check("win_row", {112'b0, cur.row}, {112'b0, e.row});
        check("win_col", {112'b0, cur.col}, {112'b0, e.col});
      end
    end
  end

  function automatic logic [DW-1:0] pix(input int x, input int y, input int mul);
    return DW'(mul * y + x);
  endfunction

  task automatic send_pix(input logic [DW-1:0] d);
    int tmo;
    tmo = 0;
    s_pix_valid = 1'b1;
    s_pix_data  = d;
    forever begin
      @(negedge clk);
      if (s_pix_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      tmo++;
      if (tmo > 200) begin
        check("pix_accept_timeout", 128'd0, 128'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_pix_valid = 1'b0;
  endtask

  task automatic do_start(input int w, input int h);
    cfg_width  = DIMW'(w);
    cfg_height = DIMW'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Feeds up to npix pixels of a WxH frame and queues the expected windows.
  task automatic feed(input int w, input int h, input int mul, input int npix);
    exp_t e;
    int n;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n >= npix) return;
        if (x >= 2 && y >= 2) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e.dat[DW*(3*r+c) +: DW] = pix(x - 2 + c, y - 2 + r, mul);
          e.row = DIMW'(y - 2);
          e.col = DIMW'(x - 2);
          sb.push_back(e);
        end
        send_pix(pix(x, y, mul));
        n++;
      end
    end
  endtask

  task automatic run_frame(input int w, input int h, input int mul, input string tag);
    int d0, tmo;
    d0 = done_cnt;
    win_cnt = 0;
    first_seen = 0;
    gap_cnt = 0;
    do_start(w, h);
    feed(w, h, mul, w * h);
    tmo = 0;
    while (done_cnt == d0 && tmo < 100) begin
      @(posedge clk);
      tmo++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 128'(done_cnt - d0), 128'd1);
    check({tag, "_win_count"}, 128'(win_cnt), 128'((w - 2) * (h - 2)));
    check({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
    check({tag, "_busy_after"}, {127'b0, busy}, 128'd0);
  endtask

  task automatic bad_start(input int w, input int h, input string tag);
    cfg_width   = DIMW'(w);
    cfg_height  = DIMW'(h);
    s_pix_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_cfg_err"}, {127'b0, cfg_err}, 128'd1);
    check({tag, "_busy"}, {127'b0, busy}, 128'd0);
    check({tag, "_pix_ready"}, {127'b0, s_pix_ready}, 128'd0);
    @(negedge clk);
    check({tag, "_cfg_err_pulse"}, {127'b0, cfg_err}, 128'd0);
    check({tag, "_still_idle"}, {126'b0, busy, s_pix_ready}, 128'd0);
    s_pix_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {m_win_data, m_win_row, m_win_col},
          128'd0);
    check("rst_flags", {123'b0, m_win_valid, busy, done, cfg_err, s_pix_ready}, 128'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Frame 1: W=5, H=4, pixel=5y+x, ready always high.
    rdy_mode = 0;
    run_frame(5, 4, 5, "f1");
    check("f1_first_window", {56'b0, first_dat}, {56'b0, 72'h0C0B0A_070605_020100});

    // Same frame with downstream stalls.
    rdy_mode = 1;
    run_frame(5, 4, 5, "f2");
    check("f2_first_window", {56'b0, first_dat}, {56'b0, 72'h0C0B0A_070605_020100});
    rdy_mode = 0;
    @(posedge clk);
    #1;

    bad_start(2, 4, "w2");
    bad_start(5, 2, "h2");
    bad_start(MAXW + 1, 4, "wmax1");

    // Reset mid-frame after 7 pixels, then a fresh 4x3 frame.
    do_start(5, 4);
    feed(5, 4, 5, 7);
    check("mid_busy", {127'b0, busy}, 128'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_flags", {126'b0, busy, m_win_valid}, 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_sb", 128'(sb.size()), 128'd0);
    @(posedge clk);
    #1;
    run_frame(4, 3, 10, "f3");
    check("f3_first_window", {56'b0, first_dat}, {56'b0, 72'h161514_0C0B0A_020100});

    // Full-width frame, continuous flow.
    run_frame(MAXW, 3, 1, "fmax");
    check("fmax_no_gaps", 128'(gap_cnt), 128'd0);
    check("fmax_done_delay", 128'(done_cyc - last_hs_cyc), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
